// File: rtl/coeff_token_flc_packer.sv
// coeff_token_flc_packer
// CAVLC coeff_token encoder for the nC >= 8 fixed-length case. It also takes
// raw {code,len} symbols and a flush command, and packs all of them MSB-first
// into WORD_W-bit words behind valid/ready handshakes.
// Optional feature: define COEFF_TOKEN_STATS_EN to build a saturating counter
// of legal coeff tokens on stat_tokens_o. Without it the output is tied to 0.
module coeff_token_flc_packer #(
  parameter int WORD_W      = 32,
  parameter int RAW_MAX_LEN = 16,
  parameter int ACC_W       = WORD_W + RAW_MAX_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [4:0]             total_coeff_cnt_i,
  input  logic [1:0]             trailing_ones_cnt_i,
  input  logic [RAW_MAX_LEN-1:0] raw_code_i,
  input  logic [4:0]             raw_len_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_word,
  output logic                   out_last,
  output logic [31:0]            bit_count_o,
  output logic                   err_o,
  output logic [15:0]            stat_tokens_o
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ACC_CNT  = CNT_W'(ACC_W);
  localparam logic [CNT_W-1:0] TOK_LEN  = CNT_W'(6);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, out_valid_q;
  logic              out_last_q, out_last_d;
  logic [31:0]       bit_count_q, bit_count_d;
  logic              err_q, err_d;

  logic              tok_legal;
  logic [5:0]        tok_code;
  logic [ACC_W-1:0]  raw_mask;
  logic              raw_too_long;
  logic [ACC_W-1:0]  app_bits;
  logic [CNT_W-1:0]  app_len;
  logic [CNT_W-1:0]  shamt;

  // T1 may not exceed TC. Because T1 is at most 3, this rule also rejects
  // T1=3 when TC<3.
  assign tok_legal = (total_coeff_cnt_i <= 5'd16) &&
                     ({3'b000, trailing_ones_cnt_i} <= total_coeff_cnt_i);
  // TC=0 has its own code. Every other TC is coded as {TC-1, T1}.
  assign tok_code  = (total_coeff_cnt_i == 5'd0) ? 6'b000011 :
                     6'({total_coeff_cnt_i - 5'd1, trailing_ones_cnt_i});
  assign raw_mask     = (ACC_W'(1) << raw_len_i) - ACC_W'(1);
  assign raw_too_long = 32'(raw_len_i) > 32'(RAW_MAX_LEN);

  // Next-state logic. The accumulator is left-aligned, and any bits below
  // cnt are always zero. Appending a symbol is therefore a plain OR at
  // bit position ACC_W-cnt-len.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_last_d  = out_last_q;
    bit_count_d = bit_count_q;
    err_d       = err_q;
    app_bits    = '0;
    app_len     = '0;
    shamt       = '0;
    if (out_valid_q) begin
      if (out_ready) begin
        acc_d      = acc_q << WORD_W;
        cnt_d      = cnt_q - WORD_CNT;
        out_last_d = 1'b0;
      end
    end else if (in_valid && in_ready_q) begin
      case (in_op)
        2'd0: begin
          if (tok_legal) begin
            app_bits = ACC_W'(tok_code);
            app_len  = TOK_LEN;
          end else begin
            err_d = 1'b1;
          end
        end
        2'd1: begin
          if (raw_too_long) begin
            err_d = 1'b1;
          end else begin
            app_bits = ACC_W'(raw_code_i) & raw_mask;
            app_len  = CNT_W'(raw_len_i);
          end
        end
        2'd2: begin
          // Padding is implicit because the bits below cnt are already zero.
          if (cnt_q != '0) begin
            cnt_d      = WORD_CNT;
            out_last_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
      shamt       = ACC_CNT - cnt_q - app_len;
      acc_d       = acc_d | (app_bits << shamt);
      cnt_d       = cnt_d + app_len;
      bit_count_d = bit_count_q + 32'(app_len);
    end
  end

  // State registers. The handshake flags are registered from cnt_d, so they
  // are never both high in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      bit_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d < WORD_CNT);
      out_valid_q <= (cnt_d >= WORD_CNT);
      out_last_q  <= out_last_d;
      bit_count_q <= bit_count_d;
      err_q       <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_word    = acc_q[ACC_W-1 -: WORD_W];
  assign out_last    = out_last_q;
  assign bit_count_o = bit_count_q;
  assign err_o       = err_q;

`ifdef COEFF_TOKEN_STATS_EN
  logic        tok_accept;
  logic [15:0] stat_q, stat_d;

  assign tok_accept = in_valid && in_ready_q && (in_op == 2'd0) && tok_legal;

  // Saturating count of legal coeff tokens.
  always_comb begin
    stat_d = stat_q;
    if (tok_accept && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
  end

  // Token statistics register.
  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_tokens_o = stat_q;
`else
  assign stat_tokens_o = '0;
`endif

endmodule

// File: tb/tb_coeff_token_flc_packer.sv
// Testbench for coeff_token_flc_packer. It runs the directed scenarios and then
// a randomized symbol stream. All results are compared against a bit-queue
// reference model.
module tb_coeff_token_flc_packer;

  localparam int WORD_W      = 32;
  localparam int RAW_MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  total_coeff_cnt_i;
  logic [1:0]  trailing_ones_cnt_i;
  logic [15:0] raw_code_i;
  logic [4:0]  raw_len_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic [31:0] bit_count_o;
  logic        err_o;
  logic [15:0] stat_tokens_o;

  coeff_token_flc_packer #(.WORD_W(WORD_W), .RAW_MAX_LEN(RAW_MAX_LEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_op               (in_op),
    .total_coeff_cnt_i   (total_coeff_cnt_i),
    .trailing_ones_cnt_i (trailing_ones_cnt_i),
    .raw_code_i          (raw_code_i),
    .raw_len_i           (raw_len_i),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_word            (out_word),
    .out_last            (out_last),
    .bit_count_o         (bit_count_o),
    .err_o               (err_o),
    .stat_tokens_o       (stat_tokens_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue holding the pending bitstream, plus the expected
  // status values.
  bit          mq[$];
  bit          m_last;
  bit          m_err;
  int unsigned m_bits;
  int unsigned m_stat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    logic [31:0] w = '0;
    for (int i = 0; i < WORD_W; i++) w = {w[30:0], mq[i]};
    return w;
  endfunction

  function automatic int unsigned exp_stat();
`ifdef COEFF_TOKEN_STATS_EN
    return m_stat;
`else
    return 0;
`endif
  endfunction

  task automatic model_apply(input int op, input int tc, input int t1,
                             input int unsigned code, input int len);
    int unsigned v;
    case (op)
      0: begin
        if (tc <= 16 && t1 <= tc) begin
          v = (tc == 0) ? 3 : (tc - 1) * 4 + t1;
          for (int i = 5; i >= 0; i--) mq.push_back(bit'((v >> i) & 1));
          m_bits += 6;
          if (m_stat < 65535) m_stat++;
        end else m_err = 1'b1;
      end
      1: begin
        if (len > RAW_MAX_LEN) m_err = 1'b1;
        else begin
          for (int i = len - 1; i >= 0; i--) mq.push_back(bit'((code >> i) & 1));
          m_bits += len;
        end
      end
      2: begin
        if (mq.size() > 0) begin
          while (mq.size() < WORD_W) mq.push_back(1'b0);
          m_last = 1'b1;
        end
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete(); m_last = 0; m_err = 0; m_bits = 0; m_stat = 0;
  endtask

  task automatic send(input int op, input int tc, input int t1,
                      input int unsigned code, input int len);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_op = 2'(op);
    total_coeff_cnt_i = 5'(tc);
    trailing_ones_cnt_i = 2'(t1);
    raw_code_i = 16'(code);
    raw_len_i = 5'(len);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_apply(op, tc, t1, code, len);
  endtask

  // Compare status against the model. If a word is pending, stall for
  // 'stall' cycles, then pop it.
  task automatic check_state(input int stall);
    logic [31:0] w;
    chk("bit_count", bit_count_o, m_bits);
    chk("err", err_o, m_err);
    chk("stat_tokens", stat_tokens_o, exp_stat());
    if (mq.size() >= WORD_W) begin
      w = m_word();
      chk("out_valid", out_valid, 1);
      chk("in_ready_low", in_ready, 0);
      chk("out_word", out_word, w);
      chk("out_last", out_last, m_last);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("hold_word", out_word, w);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (WORD_W) void'(mq.pop_front());
      m_last = 1'b0;
    end
    chk("out_valid_idle", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
    chk("out_last_idle", out_last, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0;
    total_coeff_cnt_i = '0; trailing_ones_cnt_i = '0; raw_code_i = '0; raw_len_i = '0;

    // Reset state
    do_reset(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bit_count", bit_count_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_stat", stat_tokens_o, 0);

    // Six TC=0 tokens fill one word. The four leftover bits are then flushed.
    for (int i = 0; i < 6; i++) begin
      send(0, 0, 0, 0, 0);
      if (i < 5) check_state(0);
    end
    chk("tc0_word", out_word, 32'h0C30C30C);
    chk("tc0_last", out_last, 0);
    chk("tc0_bits", bit_count_o, 36);
    check_state(0);
    send(2, 0, 0, 0, 0);
    chk("tc0_rem_word", out_word, 32'h30000000);
    chk("tc0_rem_last", out_last, 1);
    check_state(1);

    // TC=16, T1=3, then flush.
    do_reset(1);
    send(0, 16, 3, 0, 0);
    check_state(0);
    send(2, 0, 0, 0, 0);
    chk("tc16_word", out_word, 32'hFC000000);
    chk("tc16_last", out_last, 1);
    chk("tc16_bits", bit_count_o, 6);
    check_state(0);
    send(2, 0, 0, 0, 0);   // flush when empty: no-op
    check_state(0);

    // Illegal token sets the sticky error. The following legal token still appends.
    do_reset(1);
    send(0, 1, 2, 0, 0);
    chk("illegal_err", err_o, 1);
    chk("illegal_bits", bit_count_o, 0);
    check_state(0);
    send(0, 3, 3, 0, 0);
    check_state(0);
    send(2, 0, 0, 0, 0);
    chk("t3_word", out_word, 32'h2C000000);
    chk("err_sticky", err_o, 1);
    check_state(0);

    // Two full raw symbols, then a 5-cycle output stall.
    do_reset(1);
    send(1, 0, 0, 32'hFFFF, 16);
    check_state(0);
    send(1, 0, 0, 32'hFFFF, 16);
    chk("raw_word", out_word, 32'hFFFFFFFF);
    chk("raw_bits", bit_count_o, 32);
    check_state(5);

    // Raw length checks: 0 is a no-op, too long is an error, unused upper bits are masked.
    do_reset(1);
    send(1, 0, 0, 32'h1234, 0);
    check_state(0);
    send(1, 0, 0, 32'hFFFF, 17);
    check_state(0);
    send(1, 0, 0, 32'hFFF5, 3);
    send(3, 0, 0, 0, 0);
    check_state(0);
    send(2, 0, 0, 0, 0);
    chk("mask_word", out_word, 32'hA0000000);
    check_state(0);

    // Reset in mid-stream with cnt=20: buffered bits are dropped.
    do_reset(1);
    send(1, 0, 0, 32'hABCD, 16);
    send(1, 0, 0, 32'h7, 4);
    check_state(0);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_word", out_valid, 0);
      @(posedge clk); #1;
    end
    send(0, 2, 1, 0, 0);
    send(2, 0, 0, 0, 0);
    chk("midrst_word", out_word, 32'h14000000);
    chk("midrst_last", out_last, 1);
    check_state(0);

    // Randomized stream, compared against the model.
    do_reset(2);
    for (int k = 0; k < 400; k++) begin
      int r, op;
      r = int'($urandom_range(0, 99));
      op = (r < 45) ? 0 : (r < 85) ? 1 : (r < 97) ? 2 : 3;
      send(op, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
           $urandom, int'($urandom_range(0, 20)));
      check_state(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_token_flc_packer.md
Name: coeff_token_flc_packer

Overview:
- Next-generation CAVLC coeff_token stage for the nC >= 8 fixed-length case.
- Encodes the 6-bit FLC coeff_token arithmetically, so no lookup table is needed.
- Also accepts raw {code,len} symbols and a flush command, and packs everything MSB-first into WORD_W-bit words behind a valid/ready handshake.
- Sits between the CAVLC symbol generator and the slice bitstream writer.

Parameters:
- WORD_W, 32, output word width; legal range 16..64.
- RAW_MAX_LEN, 16, maximum raw code length in bits; must be <= WORD_W.
- ACC_W, WORD_W+RAW_MAX_LEN, accumulator width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  symbol valid
- in_ready  out  1  symbol accepted when in_valid && in_ready
- in_op  in  2  0=coeff token, 1=raw, 2=flush, 3=reserved
- total_coeff_cnt_i  in  5  TotalCoeff for op 0, range 0..16
- trailing_ones_cnt_i  in  2  TrailingOnes for op 0
- raw_code_i  in  RAW_MAX_LEN  raw code, right-aligned (op 1)
- raw_len_i  in  5  raw length (op 1)
- out_valid  out  1  word valid
- out_ready  in  1  downstream accepts word
- out_word  out  WORD_W  packed bits; first bit in MSB
- out_last  out  1  word was completed by a flush
- bit_count_o  out  32  total payload bits accepted, excluding flush padding; wraps at 2^32
- err_o  out  1  sticky error flag
- stat_tokens_o  out  16  coeff tokens accepted (optional feature)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Accumulator and cnt cleared to 0; out_valid=0, out_word=0, out_last=0.
  - bit_count_o=0, err_o=0, stat_tokens_o=0; in_ready=1 in the following cycle.
  - Reset mid-operation discards all buffered bits; no partial word is emitted.
- State:
  - Accumulator acc[ACC_W-1:0], left-aligned.
  - cnt = number of valid bits, range 0..WORD_W+RAW_MAX_LEN-1.
- Handshake rules:
  - in_ready = (cnt < WORD_W); out_valid = (cnt >= WORD_W). Both are registered and mutually exclusive, so input and output never fire in the same cycle.
  - out_word = acc[ACC_W-1 -: WORD_W] is held stable while out_valid && !out_ready.
  - Pop (out_valid && out_ready): acc <<= WORD_W; cnt -= WORD_W; out_last cleared.
- Op 0, coeff token:
  - TC=0: code 6'b000011.
  - TC=1..16: code = {TC-1 (4 bits), T1 (2 bits)}.
  - Length is always 6. Append: acc |= code << (ACC_W-cnt-6); cnt += 6; bit_count_o += 6.
  - Illegal input (TC>16, T1>3 impossible by width, T1>TC, or T1=3 with TC<3): symbol consumed, no bits appended, err_o set.
- Op 1, raw symbol:
  - Only the low raw_len_i bits are used; upper bits are ignored.
  - raw_len_i=0: consumed, no-op.
  - raw_len_i>RAW_MAX_LEN: consumed, no bits appended, err_o set.
- Op 2, flush:
  - cnt=0: no-op.
  - Otherwise zero-pad to cnt=WORD_W and set out_last=1 on that word.
  - Padding bits are not counted in bit_count_o.
- Op 3: consumed, no-op, err_o set.
- Latency: a symbol accepted at edge N that completes a word gives out_valid=1 after edge N (visible in cycle N+1).
- err_o stays set until reset.

Optional Feature:
- Macro COEFF_TOKEN_STATS_EN.
- Defined: stat_tokens_o increments on every legal op 0 accept, saturating at 16'hFFFF.
- Undefined: stat_tokens_o is tied to 0 and the counter logic is absent.

Test Plan:
- Reset with rst=1 for 2 cycles -> out_valid=0, in_ready=1, bit_count_o=0, err_o=0, out_word=0.
- 6 x op0 (TC=0, T1=0) -> after 6th accept: out_valid=1, out_word=32'h0C30C30C, out_last=0, bit_count_o=36; after pop cnt=4 (bits 0011).
- op0 (TC=16, T1=3) then op2 -> out_word=32'hFC000000, out_last=1, bit_count_o=6.
- op0 (TC=1, T1=2) -> accepted, err_o=1 sticky, bit_count_o unchanged; next op0 (TC=3, T1=3) appends 6'b001011 normally.
- op1 (code=16'hFFFF, len=16) x2 -> out_valid=1 with out_word=32'hFFFFFFFF; hold out_ready=0 for 5 cycles -> in_ready=0, out_word stable; release -> one pop, in_ready=1.
- Mid-stream rst with cnt=20 -> no word emitted; next op0 (TC=2, T1=1) then flush -> out_word=32'h14000000.
- With COEFF_TOKEN_STATS_EN defined, the above sequences -> stat_tokens_o counts only legal op 0 accepts; without it, stat_tokens_o=0 throughout.
